// File: rtl/im_loader_if.sv
// im_loader_if: byte-stream input and IM write-port bundle for im_loader.
//   in_data/in_valid/in_ready : 8-bit valid/ready byte stream (host -> loader)
//   im_we/im_waddr/im_wdata   : instruction-memory write port (loader -> IM)
// Modports: master = host/IM side, slave = loader side.
interface im_loader_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [15:0]       im_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, im_we, im_waddr, im_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, im_we, im_waddr, im_wdata
  );
endinterface

// File: rtl/im_loader.sv
// im_loader: receives a framed byte stream (HDR_BYTE, N, 2N payload bytes
// high-byte first, XOR checksum), writes N 16-bit words into the instruction
// memory and holds the CPU until a frame with a good checksum is resident.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : im_loader_if.slave (byte stream in, IM write port out)
//   cpu_hold  : 1 = CPU must not fetch/execute
//   done      : last frame loaded and checksum passed
//   err       : last frame rejected
// Optional: define IM_LOADER_ZERO_FILL_EN to zero addresses N..DEPTH-1 after
// the last word (in_ready low while filling) before the checksum byte.
module im_loader #(
  parameter int          ADDR_W   = 4,
  parameter int          DEPTH    = 16,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic     clk,
  input  logic     rst,
  im_loader_if.slave bus,
  output logic     cpu_hold,
  output logic     done,
  output logic     err
);

  // Counter is one bit wider than the address so N == DEPTH is representable.
  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
`ifdef IM_LOADER_ZERO_FILL_EN
    , S_FILL
`endif
  } state_e;

  state_e            state_q;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [15:0]       wdata_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;
  logic [CW-1:0]     n_q;
  logic [CW-1:0]     cnt_q;
  logic [7:0]        hi_q;
  logic [7:0]        chk_q;

  logic              accept;
  logic [CW-1:0]     cnt_inc;

  assign accept  = bus.in_valid & ready_q;
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      n_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      chk_q   <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        // DONE and ERROR restart exactly like IDLE; their flags persist
        // until the next header is accepted.
        S_IDLE, S_DONE, S_ERROR: begin
          if (accept && bus.in_data == HDR_BYTE) begin
            state_q <= S_COUNT;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
          end
        end
        S_COUNT: begin
          if (accept) begin
            if (bus.in_data == 8'd0 || bus.in_data > 8'(DEPTH)) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
              hold_q  <= 1'b1;
            end else begin
              n_q     <= CW'(bus.in_data);
              cnt_q   <= '0;
              chk_q   <= '0;
              state_q <= S_HI;
            end
          end
        end
        S_HI: begin
          if (accept) begin
            hi_q    <= bus.in_data;
            chk_q   <= chk_q ^ bus.in_data;
            state_q <= S_LO;
          end
        end
        S_LO: begin
          if (accept) begin
            we_q    <= 1'b1;
            waddr_q <= cnt_q[ADDR_W-1:0];
            wdata_q <= {hi_q, bus.in_data};
            chk_q   <= chk_q ^ bus.in_data;
            cnt_q   <= cnt_inc;
            if (cnt_inc == n_q) begin
`ifdef IM_LOADER_ZERO_FILL_EN
              if (n_q == CW'(DEPTH)) begin
                state_q <= S_CHECK;
              end else begin
                state_q <= S_FILL;
                ready_q <= 1'b0;
              end
`else
              state_q <= S_CHECK;
`endif
            end else begin
              state_q <= S_HI;
            end
          end
        end
`ifdef IM_LOADER_ZERO_FILL_EN
        // cnt_q enters holding N; one zero word per cycle through DEPTH-1.
        S_FILL: begin
          we_q    <= 1'b1;
          waddr_q <= cnt_q[ADDR_W-1:0];
          wdata_q <= '0;
          cnt_q   <= cnt_inc;
          if (cnt_inc == CW'(DEPTH)) begin
            state_q <= S_CHECK;
            ready_q <= 1'b1;
          end
        end
`endif
        S_CHECK: begin
          if (accept) begin
            if (bus.in_data == chk_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
              hold_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.im_we    = we_q;
  assign bus.im_waddr = waddr_q;
  assign bus.im_wdata = wdata_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed self-checking bench for im_loader (default build).
module tb_im_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_hold, done, err;

  im_loader_if #(.ADDR_W(4)) ifc ();

  im_loader #(
    .ADDR_W   (4),
    .DEPTH    (16),
    .HDR_BYTE (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (ifc.slave),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int          wr_cnt      = 0;
  int          wr_base     = 0;
  bit          gap_mode    = 1'b0;
  logic [15:0] mem   [16];
  logic [15:0] words [16];

  // Shadow of the instruction memory built from observed write strobes.
  always @(negedge clk) begin
    if (ifc.im_we === 1'b1) begin
      wr_cnt++;
      mem[ifc.im_waddr] = ifc.im_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one byte and returns #1 after the edge that accepted it.
  task automatic send(input logic [7:0] b);
    int waited;
    waited = 0;
    if (gap_mode) begin
      ifc.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    ifc.in_data  = b;
    ifc.in_valid = 1'b1;
    while (ifc.in_ready !== 1'b1 && waited < 64) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 64) chk("ready_timeout", 32'(ifc.in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic frame(input int n, input logic [7:0] c);
    send(8'hA5);
    chk("hdr_hold", 32'(cpu_hold), 32'd1);
    chk("hdr_done", 32'(done), 32'd0);
    chk("hdr_err",  32'(err),  32'd0);
    send(8'(n));
    for (int i = 0; i < n; i++) begin
      send(words[i][15:8]);
      chk("hi_we", 32'(ifc.im_we), 32'd0);
      send(words[i][7:0]);
      chk("wr_we",   32'(ifc.im_we),    32'd1);
      chk("wr_addr", 32'(ifc.im_waddr), 32'(i));
      chk("wr_data", 32'(ifc.im_wdata), 32'(words[i]));
    end
    send(c);
    ifc.in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_we",    32'(ifc.im_we),    32'd0);
    chk("rst_waddr", 32'(ifc.im_waddr), 32'd0);
    chk("rst_wdata", 32'(ifc.im_wdata), 32'd0);
    chk("rst_hold",  32'(cpu_hold),     32'd1);
    chk("rst_done",  32'(done),         32'd0);
    chk("rst_err",   32'(err),          32'd0);
  endtask

  initial begin
    logic [7:0] c;
    ifc.in_data  = 8'h00;
    ifc.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'hxxxx;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;

    // Good N=2 frame, checksum 12^34^AB^CD = 40
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    wr_base = wr_cnt;
    frame(2, 8'h40);
    chk("good_done", 32'(done), 32'd1);
    chk("good_hold", 32'(cpu_hold), 32'd0);
    chk("good_err",  32'(err), 32'd0);
    chk("good_wrs",  32'(wr_cnt - wr_base), 32'd2);

    // Bad checksum: writes still happen, frame rejected
    wr_base = wr_cnt;
    frame(2, 8'h41);
    chk("bad_err",  32'(err), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_hold", 32'(cpu_hold), 32'd1);
    chk("bad_wrs",  32'(wr_cnt - wr_base), 32'd2);
    frame(2, 8'h40);
    chk("retry_done", 32'(done), 32'd1);
    chk("retry_err",  32'(err), 32'd0);

    // Junk bytes discarded, then N=0 and N=17 rejected without writes
    wr_base = wr_cnt;
    send(8'h00);
    chk("junk0_done", 32'(done), 32'd1);
    send(8'hFF);
    chk("junkff_done", 32'(done), 32'd1);
    send(8'hA5);
    chk("n0_hdr_done", 32'(done), 32'd0);
    chk("n0_hdr_hold", 32'(cpu_hold), 32'd1);
    send(8'h00);
    chk("n0_err", 32'(err), 32'd1);
    chk("n0_hold", 32'(cpu_hold), 32'd1);
    send(8'hA5);
    chk("n17_hdr_err", 32'(err), 32'd0);
    send(8'h11);
    ifc.in_valid = 1'b0;
    chk("n17_err", 32'(err), 32'd1);
    chk("n17_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reject_no_we", 32'(wr_cnt - wr_base), 32'd0);

    // Full-depth frame with in_valid low every other cycle
    c = 8'h00;
    for (int i = 0; i < 16; i++) begin
      words[i] = 16'(i * 16'h1111) ^ 16'h5A0F;
      c = c ^ words[i][15:8] ^ words[i][7:0];
    end
    gap_mode = 1'b1;
    wr_base = wr_cnt;
    frame(16, c);
    gap_mode = 1'b0;
    chk("full_done", 32'(done), 32'd1);
    chk("full_hold", 32'(cpu_hold), 32'd0);
    chk("full_wrs",  32'(wr_cnt - wr_base), 32'd16);
    chk("full_mem15", 32'(mem[15]), 32'(16'hFFFF ^ 16'h5A0F));

    // Reset after the third payload byte aborts the frame
    send(8'hA5);
    send(8'h02);
    send(8'h12);
    send(8'h34);
    chk("abort_we",   32'(ifc.im_we), 32'd1);
    chk("abort_addr", 32'(ifc.im_waddr), 32'd0);
    send(8'hAB);
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals();
    chk("abort_mem0", 32'(mem[0]), 32'h1234);
    rst = 1'b0;

    // Fresh frame after abort: BE^EF^00^42 = 13
    words[0] = 16'hBEEF;
    words[1] = 16'h0042;
    frame(2, 8'h13);
    chk("fresh_done", 32'(done), 32'd1);
    chk("fresh_hold", 32'(cpu_hold), 32'd0);
    chk("fresh_mem1", 32'(mem[1]), 32'h0042);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed time limit reached, required completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
